// File: rtl/m2_sha_pkg.sv
// Shared SHA-256 definitions: control FSM states, sizing constants and the IV
// that the working register loads on abc_load.
package m2_sha_pkg;

  localparam int ROUNDS_DEFAULT = 64;
  localparam int MSG_WORDS      = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FEED  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Index 0 is word a, index 7 is word h.
  localparam logic [7:0][31:0] SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

endpackage

// File: rtl/m2_round_cnt.sv
// Round index counter: clears to 0, advances on enable, wraps after ROUNDS-1.
module m2_round_cnt #(
  parameter int ROUNDS = 64,
  parameter int RW     = 6
) (
  input  logic          clk_h,
  input  logic          rst_h,
  input  logic          en,
  input  logic          clr,
  output logic [RW-1:0] cnt,
  output logic          tc
);

  localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

  logic [RW-1:0] cnt_q, cnt_d;

  assign cnt = cnt_q;
  assign tc  = (cnt_q == LAST);

  // Next count: clear wins, otherwise step with wrap at the terminal round.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tc ? '0 : cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk_h) begin
    if (rst_h) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/m2_round_ctrl.sv
// SHA-256 compression round sequencer: LOAD the IV, run ROUNDS rounds with
// stall support, one feed-forward cycle, then a done pulse. Abort cancels
// from any state and suppresses every strobe in the abort cycle.
module m2_round_ctrl
  import m2_sha_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT,
  parameter int RW     = 6               // must satisfy ROUNDS <= 2**RW
) (
  input  logic          clk_h,
  input  logic          rst_h,
  input  logic          start,
  input  logic          stall,
  input  logic          abort,
  output logic          busy,
  output logic          abc_load,
  output logic          abc_en,
  output logic [RW-1:0] round_idx,
  output logic          w_sel,
  output logic          ff_en,
  output logic          done
);

  state_e state_q, state_d;
  logic   cnt_clr;
  logic   rnd_tc;

  m2_round_cnt #(.ROUNDS(ROUNDS), .RW(RW)) u_cnt (
    .clk_h (clk_h),
    .rst_h (rst_h),
    .en    (abc_en),
    .clr   (cnt_clr),
    .cnt   (round_idx),
    .tc    (rnd_tc)
  );

  assign busy  = (state_q != ST_IDLE);
  assign w_sel = (32'(round_idx) >= MSG_WORDS);

  // Next-state and strobes; abort overrides everything computed above it.
  always_comb begin
    state_d  = state_q;
    abc_load = 1'b0;
    abc_en   = 1'b0;
    ff_en    = 1'b0;
    done     = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        abc_load = 1'b1;
        cnt_clr  = 1'b1;
        state_d  = ST_ROUND;
      end
      ST_ROUND: begin
        abc_en = !stall;
        if (!stall && rnd_tc) state_d = ST_FEED;
      end
      ST_FEED: begin
        ff_en = !stall;
        if (!stall) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d  = ST_IDLE;
      abc_load = 1'b0;
      abc_en   = 1'b0;
      ff_en    = 1'b0;
      done     = 1'b0;
      cnt_clr  = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_h) begin
    if (rst_h) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_m2_round_ctrl.sv
// Bench for m2_round_ctrl: directed latency/stall/abort/reset scenarios with
// literal expectations, then randomized traffic, all shadowed by a position
// model compared on every negedge.
module tb_m2_round_ctrl;

  localparam int ROUNDS = 64;
  localparam int RW     = 6;

  logic          clk_h = 1'b0;
  logic          rst_h = 1'b1;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          abort = 1'b0;
  logic          busy, abc_load, abc_en, w_sel, ff_en, done;
  logic [RW-1:0] round_idx;

  m2_round_ctrl #(.ROUNDS(ROUNDS), .RW(RW)) dut (
    .clk_h     (clk_h),
    .rst_h     (rst_h),
    .start     (start),
    .stall     (stall),
    .abort     (abort),
    .busy      (busy),
    .abc_load  (abc_load),
    .abc_en    (abc_en),
    .round_idx (round_idx),
    .w_sel     (w_sel),
    .ff_en     (ff_en),
    .done      (done)
  );

  always #5 clk_h = ~clk_h;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk_h) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor records, filled at negedge.
  int load_cyc = -1, first_en = -1, last_en = -1, ff_cyc = -1, done_cyc = -1;
  int wsel_cyc = -1, en_cnt = 0, en_at_done = 0, done_cnt = 0;
  int load_q[$];

  // Reference model: op position -1 = idle, 0 = IV load, 1..ROUNDS = round
  // (step-1), ROUNDS+1 = feed-forward, ROUNDS+2 = completion.
  int  m_step = -1;
  bit  chk_on = 1'b0;

  always begin
    @(negedge clk_h);
    if (chk_on) begin
      logic [5+RW:0] exp_v, got_v;
      logic          e_ld, e_en, e_ff, e_dn;
      int            e_idx;
      e_idx = (m_step >= 1 && m_step <= ROUNDS) ? m_step - 1 : 0;
      e_ld  = (m_step == 0) && !abort;
      e_en  = (m_step >= 1 && m_step <= ROUNDS) && !stall && !abort;
      e_ff  = (m_step == ROUNDS + 1) && !stall && !abort;
      e_dn  = (m_step == ROUNDS + 2) && !abort;
      exp_v = {m_step >= 0, e_ld, e_en, e_ff, e_dn, e_idx >= 16, RW'(e_idx)};
      got_v = {busy, abc_load, abc_en, ff_en, done, w_sel, round_idx};
      chk("model_outputs", got_v, exp_v);
      chk("strobe_onehot", $countones({abc_load, abc_en, ff_en, done}) <= 1, 1);
    end
    if (abc_load) begin
      load_cyc = cyc; en_cnt = 0; first_en = -1; wsel_cyc = -1;
      load_q.push_back(cyc);
    end
    if (abc_en) begin
      en_cnt++;
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
    end
    if (busy && w_sel && wsel_cyc < 0) wsel_cyc = cyc;
    if (ff_en) ff_cyc = cyc;
    if (done) begin
      done_cyc = cyc; done_cnt++; en_at_done = en_cnt;
      if (chk_on) chk("rounds_per_op", en_cnt, ROUNDS);
    end
    @(posedge clk_h);
    if (rst_h || abort)                               m_step = -1;
    else if (m_step == -1)                            m_step = start ? 0 : -1;
    else if (m_step >= 1 && m_step <= ROUNDS + 1 && stall) m_step = m_step;
    else if (m_step == ROUNDS + 2)                    m_step = -1;
    else                                              m_step++;
    if (rst_h) chk_on = 1'b1;
  end

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  task automatic pulse_start(output int t);
    start = 1'b1; t = cyc; tick(); start = 1'b0;
  endtask

  task automatic wait_idx(input int v);
    int n = 0;
    while (!(busy && int'(round_idx) == v) && n < 200) begin tick(); n++; end
    if (n >= 200) chk("wait_idx_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int d0 = done_cnt, n = 0;
    while (done_cnt == d0 && n < 300) begin tick(); n++; end
    if (n >= 300) chk("wait_done_timeout", 0, 1);
  endtask

  initial begin
    int t, dc;
    // Reset
    rst_h = 1'b1;
    repeat (3) tick();
    rst_h = 1'b0;
    chk("reset_outs", {busy, abc_load, abc_en, ff_en, done, round_idx}, 0);
    tick();

    // Unstalled run: exact latency map
    pulse_start(t);
    wait_done();
    chk("load_lat",  load_cyc - t, 1);
    chk("first_en",  first_en - t, 2);
    chk("last_en",   last_en - t, ROUNDS + 1);
    chk("ff_lat",    ff_cyc - t, ROUNDS + 2);
    chk("done_lat",  done_cyc - t, ROUNDS + 3);
    chk("en_count",  en_at_done, ROUNDS);
    chk("wsel_rise", wsel_cyc - t, 18);
    tick();
    chk("idle_after", busy, 0);

    // Stall 3 cycles at round 10
    pulse_start(t);
    wait_idx(10);
    stall = 1'b1; tick(); tick();
    chk("stall_hold_idx", round_idx, 10);
    tick(); stall = 1'b0;
    wait_done();
    chk("stall_done_lat", done_cyc - t, 70);
    chk("stall_en_count", en_at_done, ROUNDS);
    tick();

    // Stall in LOAD ignored, 2 cycles of stall in FEED delay ff_en/done
    start = 1'b1; t = cyc; tick(); start = 1'b0;
    stall = 1'b1; tick(); stall = 1'b0;
    while (cyc < t + 66) tick();
    stall = 1'b1; tick(); tick(); stall = 1'b0;
    wait_done();
    chk("feedstall_ff",   ff_cyc - t, 68);
    chk("feedstall_done", done_cyc - t, 69);
    chk("loadstall_en",   first_en - t, 2);
    tick();

    // Abort at round 40
    pulse_start(t);
    wait_idx(40);
    dc = done_cnt;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_idx", round_idx, 0);
    repeat (5) tick();
    chk("abort_no_done", done_cnt, dc);
    pulse_start(t);
    wait_done();
    chk("post_abort_done", done_cyc - t, 67);
    tick();

    // start held high: back-to-back every 68 cycles
    load_q.delete();
    start = 1'b1; t = cyc;
    repeat (2 * 68 + 10) tick();
    start = 1'b0;
    wait_done();
    chk("b2b_first", load_q.size() > 0 ? load_q[0] - t : -1, 1);
    chk("b2b_gap1",  load_q.size() > 1 ? load_q[1] - load_q[0] : -1, 68);
    chk("b2b_gap2",  load_q.size() > 2 ? load_q[2] - load_q[1] : -1, 68);
    tick();

    // Reset at round 20
    pulse_start(t);
    wait_idx(20);
    dc = done_cnt;
    rst_h = 1'b1; tick(); rst_h = 1'b0;
    chk("midrst_outs", {busy, abc_load, abc_en, ff_en, done, round_idx}, 0);
    repeat (70) tick();
    chk("midrst_no_done", done_cnt, dc);

    // start with abort in IDLE stays idle; then a normal start
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy, 0);
    pulse_start(t);
    wait_done();
    chk("post_rst_done", done_cyc - t, 67);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 99) == 0);
      rst_h = ($urandom_range(0, 299) == 0);
      tick();
    end
    start = 1'b0; stall = 1'b0; abort = 1'b0; rst_h = 1'b0;
    repeat (80) tick();
    chk("drain_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/m2_round_ctrl.md
M2_ROUND_CTRL -- requirements
Module: m2_round_ctrl

Interface
REQ-001 Parameter ROUNDS, default 64; number of compression rounds per block.
REQ-002 Parameter RW, default 6; round index width, with ROUNDS <= 2**RW.
REQ-003 clk_h  in  1  single block clock; all logic on posedge.
REQ-004 rst_h  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request a compression; sampled only in IDLE.
REQ-006 stall  in  1  hold round progress this cycle; honoured in ROUND and FEED only.
REQ-007 abort  in  1  cancel the current operation and return to IDLE.
REQ-008 busy  out  1  high whenever state != IDLE.
REQ-009 abc_load  out  1  one-cycle pulse that loads the IV into the a..h working register.
REQ-010 abc_en  out  1  working-register shift enable, one per executed round.
REQ-011 round_idx  out  RW  current round number, addresses the K ROM and the W scheduler.
REQ-012 w_sel  out  1  0 = message word input (rounds 0..15); 1 = expanded W (rounds 16..ROUNDS-1).
REQ-013 ff_en  out  1  feed-forward add enable (hash state += a..h).
REQ-014 done  out  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, ROUND, FEED and DONE, encoded per the shared package.
REQ-016 IDLE: start=1 and abort=0 SHALL move to LOAD; otherwise the FSM stays in IDLE.
REQ-017 LOAD: abc_load=1 for exactly one cycle, round_idx=0, then ROUND; stall SHALL be ignored in LOAD.
REQ-018 ROUND: abc_en SHALL equal !stall.
REQ-019 ROUND: round_idx SHALL increment on each cycle with abc_en=1.
REQ-020 ROUND: round_idx SHALL hold while stall=1.
REQ-021 ROUND: an enabled cycle at round_idx=ROUNDS-1 SHALL move to FEED, and round_idx SHALL wrap to 0.
REQ-022 w_sel SHALL be combinational from round_idx: 1 iff round_idx >= 16.
REQ-023 FEED: ff_en SHALL equal !stall, and the first unstalled FEED cycle SHALL move to DONE.
REQ-024 DONE: done=1 for one cycle, then IDLE.
REQ-025 start asserted in any state other than IDLE SHALL be ignored, not queued.
REQ-026 Unstalled latency: start at cycle T gives abc_load at T+1, abc_en at T+2..T+ROUNDS+1, ff_en at T+ROUNDS+2 and done at T+ROUNDS+3; busy is high over T+1..T+ROUNDS+3.
REQ-027 Total abc_en pulses per completed operation SHALL be exactly ROUNDS, regardless of stall pattern.
REQ-028 abort in any state SHALL move to IDLE on the next edge, with round_idx=0 and no done pulse.
REQ-029 In the abort cycle itself, abc_en, ff_en and abc_load SHALL be forced to 0.
REQ-030 abort has priority over start, stall and every state transition.
REQ-031 The outputs abc_load, abc_en, ff_en and done SHALL be mutually exclusive in every cycle.

Reset
REQ-032 rst_h=1 at a clock edge SHALL force: state=IDLE, round_idx=0, and busy, abc_load, abc_en, ff_en, done all 0.
REQ-033 Reset mid-operation SHALL discard the operation with no done pulse; reset has priority over abort.
REQ-034 The first start after rst_h deasserts SHALL be accepted normally.

Structure
REQ-035 Shared package m2_sha_pkg SHALL hold:
- FSM state typedef;
- ROUNDS_DEFAULT=64 and MSG_WORDS=16;
- SHA-256 IV constants, shared with the working register.
REQ-036 The round counter SHALL be one sub-module, m2_round_cnt, with enable, clear, terminal-count output and wrap at ROUNDS-1; all other logic is inline.

Verification
REQ-037 Unstalled run: rst_h, then start pulse at T=0 -> abc_load@1, 64 abc_en @2..65, ff_en@66, done@67.
REQ-038 Unstalled run: w_sel toggles 0->1 when round_idx reaches 16.
REQ-039 Stall: stall=1 for 3 cycles at round_idx=10 -> round_idx held at 10, done@70, exactly 64 abc_en pulses.
REQ-040 Stall: stall during LOAD -> ignored; stall during FEED -> ff_en and done delayed 1 cycle per stalled cycle.
REQ-041 Abort at round_idx=40 -> IDLE next cycle, round_idx=0, no done; new start then completes with done 67 cycles later.
REQ-042 start held high continuously -> back-to-back operations, one every 68 cycles, no start accepted while busy=1.
REQ-043 rst_h asserted at round_idx=20 -> all outputs 0 next cycle; start with abort high in IDLE -> stays IDLE.
